// File: rtl/ifetch_rsp.sv
// Instruction-fetch responder: one outstanding SRAM read per request, with timeout, hold buffer, flush kill.
// Latency: strobe on the cycle after accept; instruction registered on the edge that samples mem_rvalid_i.
// Backpressure: hold_i freezes outputs; a response arriving during hold parks in a one-entry buffer.
module ifetch_rsp #(
  parameter int                 ADDR_W  = 32,
  parameter int                 DATA_W  = 32,
  parameter int                 TIMEOUT = 16,
  parameter logic [DATA_W-1:0]  NOP     = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              re_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

  // Last count value before the fetch is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                kill_q, kill_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic                ivld_q, ivld_d;

  // Decode-side load request produced by the FSM this cycle.
  logic                load;
  logic [DATA_W-1:0]   load_dat;

  // Next-state and next-register logic; flush outranks response/timeout, which outrank hold.
  always_comb begin
    state_d  = state_q;
    req_d    = 1'b0;
    addr_d   = addr_q;
    kill_d   = kill_q;
    tmo_d    = tmo_q;
    buf_d    = buf_q;
    err_d    = 1'b0;
    load     = 1'b0;
    load_dat = buf_q;

    case (state_q)
      IDLE: begin
        // A stray or late response in IDLE is simply not looked at.
        if (re_i && !flush_i) begin
          addr_d  = pc_i;
          req_d   = 1'b1;
          kill_d  = 1'b0;
          tmo_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          if (kill_q || flush_i) begin
            state_d = IDLE;
          end else if (!hold_i) begin
            load     = 1'b1;
            load_dat = mem_rdata_i;
            state_d  = IDLE;
          end else begin
            buf_d   = mem_rdata_i;
            state_d = FULL;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Error is reported even for a killed fetch; only the NOP load is suppressed.
          err_d = 1'b1;
          if (!kill_q && !flush_i && !hold_i) begin
            load     = 1'b1;
            load_dat = NOP;
          end
          state_d = IDLE;
        end
      end
      FULL: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (!hold_i) begin
          load     = 1'b1;
          load_dat = buf_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output registers: flush clears, a load presents once, hold freezes, otherwise valid drops.
    inst_d  = inst_q;
    iaddr_d = iaddr_q;
    ivld_d  = ivld_q;
    if (flush_i) begin
      ivld_d = 1'b0;
      inst_d = NOP;
    end else if (load) begin
      inst_d  = load_dat;
      iaddr_d = addr_q;
      ivld_d  = 1'b1;
    end else if (!hold_i) begin
      ivld_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      kill_q  <= 1'b0;
      tmo_q   <= 8'd0;
      buf_q   <= '0;
      err_q   <= 1'b0;
      inst_q  <= NOP;
      iaddr_q <= '0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
      iaddr_q <= iaddr_d;
      ivld_q  <= ivld_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign mem_req_o    = req_q;
  assign mem_addr_o   = addr_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = iaddr_q;
  assign inst_valid_o = ivld_q;
  assign err_o        = err_q;

endmodule
